// File: rtl/pc_gen_unit_pkg.sv
// Shared definitions for the fetch program-counter generator: state encoding,
// redirect-kind constants and a constant-evaluable log2 helper.
package pc_gen_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam logic KIND_BRANCH = 1'b0;
    localparam logic KIND_TRAP   = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch-side bundle of the PC generator: hazard/handshake inputs, redirects,
// halt control and the registered fetch request.
// Handshake: a fetch of pc_out happens on a rising edge where fetch_valid,
// fetch_ready and pc_write are all 1; fetch_valid never waits on fetch_ready.
interface pc_gen_if #(
    parameter int XLEN = 64
);
    logic            pc_write;
    logic            fetch_ready;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vector;
    logic            halt_req;
    logic            resume;
    logic [XLEN-1:0] pc_out;
    logic            fetch_valid;
    logic            misaligned;
    logic            halted;

    modport master (
        output pc_write, fetch_ready, branch_taken, branch_target,
               trap_valid, trap_vector, halt_req, resume,
        input  pc_out, fetch_valid, misaligned, halted
    );

    modport slave (
        input  pc_write, fetch_ready, branch_taken, branch_target,
               trap_valid, trap_vector, halt_req, resume,
        output pc_out, fetch_valid, misaligned, halted
    );
endinterface

// File: rtl/pc_gen_unit_next_sel.sv
// Next-PC priority mux: trap > pending redirect > branch > sequential increment.
module pc_next_sel #(
    parameter int XLEN       = 64,
    parameter int INST_BYTES = 4
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_vector,
    input  logic            i_pend_valid,
    input  logic [XLEN-1:0] i_pend_addr,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_used_pend
);
    logic [XLEN-1:0] w_seq_pc;

    // Wraps modulo 2^XLEN by construction.
    assign w_seq_pc = i_pc + XLEN'(INST_BYTES);

    always_comb begin
        o_next_pc   = w_seq_pc;
        o_used_pend = 1'b0;
        if (i_trap_valid) begin
            o_next_pc = i_trap_vector;
        end else if (i_pend_valid) begin
            o_next_pc   = i_pend_addr;
            o_used_pend = 1'b1;
        end else if (i_branch_taken) begin
            o_next_pc = i_branch_target;
        end
    end
endmodule

// File: rtl/pc_gen_unit.sv
// IF-stage program counter: boot delay, fetch handshake, one-entry redirect
// buffer across stalls/halts, halt/resume and misalignment flagging.
module pc_gen_unit
    import pc_gen_unit_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INST_BYTES   = 4,
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    pc_gen_if.slave      bus,
    output pc_state_e    o_dbg_state
);
    localparam int ALIGN = clog2(INST_BYTES);
    localparam int BCW   = (BOOT_CYCLES > 1) ? clog2(BOOT_CYCLES) : 1;
    localparam pc_state_e RESET_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic [BCW-1:0]  r_boot_cnt;
    logic            r_pend_valid;
    logic            r_pend_kind;
    logic [XLEN-1:0] r_pend_addr;

    logic            w_run, w_mis, w_fetch_valid, w_advance;
    logic            w_pend_trap, w_recover, w_load;
    logic            w_pend_en, w_br_en, w_used_pend, w_keep_branch;
    logic [XLEN-1:0] w_br_tgt, w_next_pc;

    assign w_run         = (r_state == ST_RUN);
    assign w_mis         = |r_pc[ALIGN-1:0];
    assign w_fetch_valid = w_run & ~w_mis;
    assign w_advance     = bus.pc_write & bus.fetch_ready & w_fetch_valid;
    assign w_pend_trap   = r_pend_valid & (r_pend_kind == KIND_TRAP);
    // A misaligned PC can only be escaped through a trap (new or pending).
    assign w_recover     = w_run & w_mis & (bus.trap_valid | w_pend_trap);
    assign w_load        = w_advance | w_recover;
    assign w_pend_en     = r_pend_valid & (~w_mis | w_pend_trap);
    assign w_br_en       = bus.branch_taken & ~w_mis;
    assign w_br_tgt      = bus.branch_target & ~XLEN'(1);
    // A branch that loses the mux to an older pending entry is buffered, not dropped.
    assign w_keep_branch = bus.branch_taken & ~bus.trap_valid & (w_used_pend | w_mis);

    pc_next_sel #(
        .XLEN       (XLEN),
        .INST_BYTES (INST_BYTES)
    ) u_next_sel (
        .i_pc            (r_pc),
        .i_trap_valid    (bus.trap_valid),
        .i_trap_vector   (bus.trap_vector),
        .i_pend_valid    (w_pend_en),
        .i_pend_addr     (r_pend_addr),
        .i_branch_taken  (w_br_en),
        .i_branch_target (w_br_tgt),
        .o_next_pc       (w_next_pc),
        .o_used_pend     (w_used_pend)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= RESET_STATE;
            r_pc         <= RESET_VECTOR;
            r_boot_cnt   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_kind  <= KIND_BRANCH;
            r_pend_addr  <= '0;
        end else begin
            if (w_load) begin
                r_pc <= w_next_pc;
                if (w_keep_branch) begin
                    r_pend_valid <= 1'b1;
                    r_pend_kind  <= KIND_BRANCH;
                    r_pend_addr  <= w_br_tgt;
                end else begin
                    r_pend_valid <= 1'b0;
                end
            end else if (bus.trap_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_kind  <= KIND_TRAP;
                r_pend_addr  <= bus.trap_vector;
            end else if (bus.branch_taken && !w_pend_trap) begin
                r_pend_valid <= 1'b1;
                r_pend_kind  <= KIND_BRANCH;
                r_pend_addr  <= w_br_tgt;
            end

            case (r_state)
                ST_BOOT: begin
                    r_boot_cnt <= r_boot_cnt + 1'b1;
                    if (r_boot_cnt == BCW'(BOOT_CYCLES - 1)) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.halt_req) r_state <= ST_HALT;
                end
                ST_HALT: begin
                    if (bus.resume && !bus.halt_req) r_state <= ST_RUN;
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign bus.pc_out      = r_pc;
    assign bus.fetch_valid = w_fetch_valid;
    assign bus.misaligned  = w_mis;
    assign bus.halted      = (r_state == ST_HALT);
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: boot, sequential wrap, stall buffering,
// redirect priority, halt/resume, misalignment recovery and mid-run reset.
module tb_pc_gen_unit;
  import pc_gen_unit_pkg::*;

  localparam int XLEN = 64;

  logic      clock;
  logic      reset_n;
  pc_state_e dbg_state;
  int        n_checks;
  int        n_errors;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (64'h1000),
    .INST_BYTES   (4),
    .BOOT_CYCLES  (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pc_write      = 1'b1;
    bus.fetch_ready   = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.trap_valid    = 1'b0;
    bus.trap_vector   = '0;
    bus.halt_req      = 1'b0;
    bus.resume        = 1'b0;
  endtask

  task automatic pulse_trap(input logic [XLEN-1:0] vec);
    bus.trap_valid  = 1'b1;
    bus.trap_vector = vec;
    tick();
    bus.trap_valid  = 1'b0;
  endtask

  task automatic pulse_branch(input logic [XLEN-1:0] tgt);
    bus.branch_taken  = 1'b1;
    bus.branch_target = tgt;
    tick();
    bus.branch_taken  = 1'b0;
  endtask

  // checker
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    idle_inputs();

    // T1 reset and boot delay
    tick();
    check("rst_pc", bus.pc_out, 64'h1000);
    check("rst_fv", 64'(bus.fetch_valid), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_mis", 64'(bus.misaligned), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_BOOT));
    reset_n = 1'b1;
    tick();
    check("boot1_fv", 64'(bus.fetch_valid), 64'd0);
    check("boot1_pc", bus.pc_out, 64'h1000);
    tick();
    check("boot2_fv", 64'(bus.fetch_valid), 64'd1);
    check("boot2_pc", bus.pc_out, 64'h1000);
    check("run_state", 64'(dbg_state), 64'(ST_RUN));
    tick();
    check("first_adv", bus.pc_out, 64'h1004);

    // T2 sequential increment and wrap
    pulse_trap(64'hFFFF_FFFF_FFFF_FFFC);
    check("pre_wrap", bus.pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap", bus.pc_out, 64'h0);
    for (int i = 0; i < 4; i++) tick();
    check("seq4", bus.pc_out, 64'h10);

    // T3 branch buffered across a stall
    bus.pc_write = 1'b0;
    pulse_branch(64'h2001);
    check("stall_hold1", bus.pc_out, 64'h10);
    tick();
    check("stall_hold2", bus.pc_out, 64'h10);
    bus.pc_write = 1'b1;
    tick();
    check("stall_release", bus.pc_out, 64'h2000);
    tick();
    check("after_pend", bus.pc_out, 64'h2004);

    // T4 trap beats a pending branch and clears it
    bus.fetch_ready = 1'b0;
    pulse_branch(64'h2000);
    check("nr_hold", bus.pc_out, 64'h2004);
    bus.fetch_ready = 1'b1;
    pulse_trap(64'h8000);
    check("trap_prio", bus.pc_out, 64'h8000);
    tick();
    check("pend_cleared", bus.pc_out, 64'h8004);

    // T5 halt with same-edge advance, trap pended while halted
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    check("halt_pc", bus.pc_out, 64'h8008);
    check("halt_flag", 64'(bus.halted), 64'd1);
    check("halt_fv", 64'(bus.fetch_valid), 64'd0);
    tick();
    check("halt_hold", bus.pc_out, 64'h8008);
    pulse_trap(64'h9000);
    check("halt_trap_hold", bus.pc_out, 64'h8008);
    bus.halt_req = 1'b1;
    bus.resume   = 1'b1;
    tick();
    check("halt_both", 64'(bus.halted), 64'd1);
    bus.halt_req = 1'b0;
    tick();
    bus.resume = 1'b0;
    check("resume_flag", 64'(bus.halted), 64'd0);
    check("resume_fv", 64'(bus.fetch_valid), 64'd1);
    check("resume_pc", bus.pc_out, 64'h8008);
    tick();
    check("resume_trap", bus.pc_out, 64'h9000);

    // T6 misaligned trap target, branch cannot recover, trap can
    pulse_trap(64'h3002);
    check("mis_pc", bus.pc_out, 64'h3002);
    check("mis_flag", 64'(bus.misaligned), 64'd1);
    check("mis_fv", 64'(bus.fetch_valid), 64'd0);
    pulse_branch(64'h5000);
    check("mis_branch_hold", bus.pc_out, 64'h3002);
    pulse_trap(64'h4000);
    check("mis_recover", bus.pc_out, 64'h4000);
    check("mis_cleared", 64'(bus.misaligned), 64'd0);
    check("mis_fv_back", 64'(bus.fetch_valid), 64'd1);
    tick();
    check("mis_next", bus.pc_out, 64'h4004);

    // asynchronous reset mid-run
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pc", bus.pc_out, 64'h1000);
    check("async_rst_fv", 64'(bus.fetch_valid), 64'd0);
    check("async_rst_state", 64'(dbg_state), 64'(ST_BOOT));

    // report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
